// File: rtl/alu16_seq.sv
// alu16_seq: sequences a 16-bit operation over an external combinational
// 8-bit ALU in two byte steps (IDLE -> STEP1 -> STEP2 -> FINISH -> IDLE).
//
// Configuration macro: ALU16_SHIFT_EN enables shift/rotate ops 9-13.
// Without it those op codes are rejected with ERR, exactly like op 15.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start, i_op, i_a16,
//   i_b16, i_cin            request, op code, operands and carry-in
//   o_alu_sel, o_alu_a,
//   o_alu_b, o_alu_cin      drive to the external 8-bit ALU
//   i_alu_result, i_alu_c,
//   i_alu_z                 same-cycle return from the external ALU
//   o_busy, o_done, o_err   status (done/err are one-cycle pulses)
//   o_result16, o_c, o_z    registered 16-bit result and flags
module alu16_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [15:0] i_a16,
    input  logic [15:0] i_b16,
    input  logic        i_cin,
    output logic [3:0]  o_alu_sel,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    output logic        o_alu_cin,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_c,
    input  logic        i_alu_z,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_result16,
    output logic        o_c,
    output logic        o_z
);

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_BYTE = 8;
    localparam int unsigned W_OP   = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP1  = 2'd1;
    localparam logic [1:0] S_STEP2  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [W_OP-1:0] OP_ADD  = 4'd0;
    localparam logic [W_OP-1:0] OP_ADDC = 4'd1;
    localparam logic [W_OP-1:0] OP_SUB  = 4'd2;
    localparam logic [W_OP-1:0] OP_SUBC = 4'd3;
    localparam logic [W_OP-1:0] OP_CMP  = 4'd4;
    localparam logic [W_OP-1:0] OP_AND  = 4'd5;
    localparam logic [W_OP-1:0] OP_OR   = 4'd6;
    localparam logic [W_OP-1:0] OP_EXOR = 4'd7;
    localparam logic [W_OP-1:0] OP_TEST = 4'd8;
`ifdef ALU16_SHIFT_EN
    localparam logic [W_OP-1:0] OP_LSL  = 4'd9;
    localparam logic [W_OP-1:0] OP_LSR  = 4'd10;
    localparam logic [W_OP-1:0] OP_ROL  = 4'd11;
    localparam logic [W_OP-1:0] OP_ROR  = 4'd12;
    localparam logic [W_OP-1:0] OP_ASR  = 4'd13;
`endif
    localparam logic [W_OP-1:0] OP_MOV  = 4'd14;

    // Op codes this build accepts.
    function automatic logic f_supported(input logic [W_OP-1:0] op);
`ifdef ALU16_SHIFT_EN
        return op != 4'd15;
`else
        return (op <= OP_TEST) || (op == OP_MOV);
`endif
    endfunction

    // ALU select for the first byte step.
    function automatic logic [W_OP-1:0] f_sel1(input logic [W_OP-1:0] op);
        logic [W_OP-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD:                                  sel = OP_ADD;
            OP_ADDC:                                 sel = OP_ADDC;
            OP_SUB, OP_CMP:                          sel = OP_SUB;
            OP_SUBC:                                 sel = OP_SUBC;
            OP_AND, OP_OR, OP_EXOR, OP_TEST, OP_MOV: sel = op;
`ifdef ALU16_SHIFT_EN
            OP_LSL, OP_ROL:                          sel = OP_LSL;
            OP_LSR, OP_ROR:                          sel = OP_LSR;
            OP_ASR:                                  sel = OP_ASR;
`endif
            default:                                 sel = '0;
        endcase
        return sel;
    endfunction

    // ALU select for the second byte step (always the carry-chaining form).
    function automatic logic [W_OP-1:0] f_sel2(input logic [W_OP-1:0] op);
        logic [W_OP-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD, OP_ADDC:                         sel = OP_ADDC;
            OP_SUB, OP_SUBC, OP_CMP:                 sel = OP_SUBC;
            OP_AND, OP_OR, OP_EXOR, OP_TEST, OP_MOV: sel = op;
`ifdef ALU16_SHIFT_EN
            OP_LSL, OP_ROL:                          sel = OP_LSL;
            OP_LSR, OP_ROR, OP_ASR:                  sel = OP_LSR;
`endif
            default:                                 sel = '0;
        endcase
        return sel;
    endfunction

    // Ops whose second step consumes the first step's carry/borrow.
    function automatic logic f_chain(input logic [W_OP-1:0] op);
        logic ch;
        ch = 1'b0;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: ch = 1'b1;
`ifdef ALU16_SHIFT_EN
            OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR:   ch = 1'b1;
`endif
            default:                                  ch = 1'b0;
        endcase
        return ch;
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [W_OP-1:0]   r_op;
    logic [W_DATA-1:0] r_a;
    logic [W_DATA-1:0] r_b;
    logic [W_BYTE-1:0] r_byte1;
    logic [W_BYTE-1:0] r_byte2;
    logic              r_z1;
    logic              r_z2;
    logic              r_c2;

    logic              w_accept;
    logic              w_first_hi_new;
    logic              w_first_hi_lat;
    logic              w_cin1;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic [W_OP-1:0]   w_alu_sel_nxt;
    logic [W_BYTE-1:0] w_alu_a_nxt;
    logic [W_BYTE-1:0] w_alu_b_nxt;
    logic              w_alu_cin_nxt;

    assign w_accept = (r_state == S_IDLE) && i_start && f_supported(i_op);

    // Right-type ops (shift toward bit 0) walk high byte first.
`ifdef ALU16_SHIFT_EN
    assign w_first_hi_new = (i_op == OP_LSR) || (i_op == OP_ROR) || (i_op == OP_ASR);
    assign w_first_hi_lat = (r_op == OP_LSR) || (r_op == OP_ROR) || (r_op == OP_ASR);
`else
    assign w_first_hi_new = 1'b0;
    assign w_first_hi_lat = 1'b0;
`endif

    // First-step carry-in: rotates feed back the bit that wraps around.
    always_comb begin
        w_cin1 = 1'b0;
        case (i_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: w_cin1 = i_cin;
`ifdef ALU16_SHIFT_EN
            OP_LSL, OP_LSR:                           w_cin1 = i_cin;
            OP_ROL:                                   w_cin1 = i_a16[15];
            OP_ROR:                                   w_cin1 = i_a16[0];
`endif
            default:                                  w_cin1 = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_alu_sel_nxt = '0;
        w_alu_a_nxt   = '0;
        w_alu_b_nxt   = '0;
        w_alu_cin_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_STEP1;
                    w_busy_nxt    = 1'b1;
                    w_alu_sel_nxt = f_sel1(i_op);
                    w_alu_a_nxt   = w_first_hi_new ? i_a16[15:8] : i_a16[7:0];
                    w_alu_b_nxt   = w_first_hi_new ? i_b16[15:8] : i_b16[7:0];
                    w_alu_cin_nxt = w_cin1;
                end else if (i_start) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_STEP1: begin
                w_state_nxt   = S_STEP2;
                w_busy_nxt    = 1'b1;
                w_alu_sel_nxt = f_sel2(r_op);
                w_alu_a_nxt   = w_first_hi_lat ? r_a[7:0] : r_a[15:8];
                w_alu_b_nxt   = w_first_hi_lat ? r_b[7:0] : r_b[15:8];
                w_alu_cin_nxt = f_chain(r_op) & i_alu_c;
            end
            S_STEP2: begin
                w_state_nxt = S_FINISH;
                w_busy_nxt  = 1'b1;
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_alu_sel <= '0;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_cin <= 1'b0;
        end else begin
            o_busy    <= w_busy_nxt;
            o_done    <= w_done_nxt;
            o_err     <= w_err_nxt;
            o_alu_sel <= w_alu_sel_nxt;
            o_alu_a   <= w_alu_a_nxt;
            o_alu_b   <= w_alu_b_nxt;
            o_alu_cin <= w_alu_cin_nxt;
        end
    end

    // Operand latch, per-step byte capture and final result update.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_byte1    <= '0;
            r_byte2    <= '0;
            r_z1       <= 1'b0;
            r_z2       <= 1'b0;
            r_c2       <= 1'b0;
            o_result16 <= '0;
            o_c        <= 1'b0;
            o_z        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= i_op;
                        r_a  <= i_a16;
                        r_b  <= i_b16;
                    end
                end
                S_STEP1: begin
                    r_byte1 <= i_alu_result;
                    r_z1    <= i_alu_z;
                end
                S_STEP2: begin
                    r_byte2 <= i_alu_result;
                    r_z2    <= i_alu_z;
                    r_c2    <= i_alu_c;
                end
                S_FINISH: begin
                    o_c <= r_c2;
                    // ALU zero flag per byte: 16-bit zero needs both bytes zero.
                    o_z <= r_z1 & r_z2;
                    // CMP and TEST only update the flags.
                    if ((r_op != OP_CMP) && (r_op != OP_TEST)) begin
                        o_result16 <= w_first_hi_lat ? {r_byte1, r_byte2}
                                                     : {r_byte2, r_byte1};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic        alu_z;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result16;
    logic        c;
    logic        z;

    int n_vec;
    int n_err;

    logic [15:0] exp_res;
    logic        exp_c;
    logic        exp_z;

    alu16_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_a16        (a16),
        .i_b16        (b16),
        .i_cin        (cin),
        .o_alu_sel    (alu_sel),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_cin    (alu_cin),
        .i_alu_result (alu_res),
        .i_alu_c      (alu_c),
        .i_alu_z      (alu_z),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_result16   (result16),
        .o_c          (c),
        .o_z          (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-bit ALU (combinational); C is carry out or borrow.
    logic [8:0] alu_t;
    always_comb begin
        alu_t   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (alu_sel)
            4'd0:  begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = alu_t[7:0]; alu_c = alu_t[8]; end
            4'd1:  begin alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin); alu_res = alu_t[7:0]; alu_c = alu_t[8]; end
            4'd2, 4'd4:
                   begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_res = alu_t[7:0]; alu_c = alu_t[8]; end
            4'd3:  begin alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin); alu_res = alu_t[7:0]; alu_c = alu_t[8]; end
            4'd5, 4'd8: alu_res = alu_a & alu_b;
            4'd6:  alu_res = alu_a | alu_b;
            4'd7:  alu_res = alu_a ^ alu_b;
            4'd9:  begin alu_res = {alu_a[6:0], alu_cin}; alu_c = alu_a[7]; end
            4'd10: begin alu_res = {alu_cin, alu_a[7:1]}; alu_c = alu_a[0]; end
            4'd13: begin alu_res = {alu_a[7], alu_a[7:1]}; alu_c = alu_a[0]; end
            4'd14: alu_res = alu_b;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == 8'h00);
    end

    // Whole-word reference: updates exp_res/exp_c/exp_z for one operation.
    function automatic void ref_apply(input logic [3:0] o, input logic [15:0] a,
                                      input logic [15:0] b, input logic ci);
        int unsigned ua;
        int unsigned ub;
        int unsigned sum;
        logic [15:0] r;
        ua  = 32'(a);
        ub  = 32'(b);
        sum = 0;
        r   = exp_res;
        case (o)
            4'd0: begin sum = ua + ub; r = 16'(sum); exp_c = (sum > 32'hFFFF); end
            4'd1: begin sum = ua + ub + 32'(ci); r = 16'(sum); exp_c = (sum > 32'hFFFF); end
            4'd2: begin r = a - b; exp_c = (ua < ub); end
            4'd3: begin r = a - b - 16'(ci); exp_c = (ua < ub + 32'(ci)); end
            4'd4: begin exp_c = (ua < ub); exp_z = (a == b); return; end
            4'd5: begin r = a & b; exp_c = 1'b0; end
            4'd6: begin r = a | b; exp_c = 1'b0; end
            4'd7: begin r = a ^ b; exp_c = 1'b0; end
            4'd8: begin exp_c = 1'b0; exp_z = ((a & b) == 16'h0); return; end
            4'd9:  begin r = {a[14:0], ci};    exp_c = a[15]; end
            4'd10: begin r = {ci, a[15:1]};    exp_c = a[0];  end
            4'd11: begin r = {a[14:0], a[15]}; exp_c = a[15]; end
            4'd12: begin r = {a[0], a[15:1]};  exp_c = a[0];  end
            4'd13: begin r = {a[15], a[15:1]}; exp_c = a[0];  end
            4'd14: begin r = b; exp_c = 1'b0; end
            default: return;
        endcase
        exp_res = r;
        exp_z   = (r == 16'h0);
    endfunction

    // Issue one request from just after a clock edge; report DONE latency.
    task automatic do_op(input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic ci,
                         output int lat);
        op = o; a16 = a; b16 = b; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = '0; a16 = '0; b16 = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, err, c, z} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got=%b want=00000", {busy, done, err, c, z});
        end
        n_vec++;
        if (result16 !== 16'h0) begin
            n_err++; $display("FAIL reset_result got=%h want=0000", result16);
        end
        n_vec++;
        if ({alu_sel, alu_a, alu_b, alu_cin} !== 21'h0) begin
            n_err++; $display("FAIL reset_alu got=%h want=0", {alu_sel, alu_a, alu_b, alu_cin});
        end
        rst_n = 1'b1;
        exp_res = '0; exp_c = 1'b0; exp_z = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [3:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic ci);
        int lat;
        do_op(o, a, b, ci, lat);
        ref_apply(o, a, b, ci);
        n_vec++;
        if (lat != 3) begin
            n_err++; $display("FAIL %s_latency op=%0d got=%0d want=3", name, o, lat);
        end
        n_vec++;
        if (result16 !== exp_res) begin
            n_err++; $display("FAIL %s_result op=%0d a=%h b=%h cin=%b got=%h want=%h", name, o, a, b, ci, result16, exp_res);
        end
        n_vec++;
        if ({c, z} !== {exp_c, exp_z}) begin
            n_err++; $display("FAIL %s_flags op=%0d a=%h b=%h cin=%b got cz=%b%b want=%b%b", name, o, a, b, ci, c, z, exp_c, exp_z);
        end
    endtask

    task automatic test_directed;
        check_op("add_ff_1", 4'd0, 16'h00FF, 16'h0001, 1'b0);
        check_op("sub_0_1", 4'd2, 16'h0000, 16'h0001, 1'b0);
        check_op("sub_1000_1", 4'd2, 16'h1000, 16'h0001, 1'b0);
        check_op("load_abcd", 4'd0, 16'hABCD, 16'h0000, 1'b1);
        check_op("cmp_eq", 4'd4, 16'h1234, 16'h1234, 1'b0);
        n_vec++;
        if ({result16, c, z} !== {16'hABCD, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL cmp_keep got=%h c=%b z=%b want=abcd c=0 z=1", result16, c, z);
        end
        check_op("addc_chain", 4'd1, 16'hFFFF, 16'h0000, 1'b1);
        check_op("subc_chain", 4'd3, 16'h0100, 16'h00FF, 1'b1);
        check_op("test_zero", 4'd8, 16'hF0F0, 16'h0F0F, 1'b0);
    endtask

    task automatic test_alu_drive;
        op = 4'd0; a16 = 16'h12F0; b16 = 16'h0220; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a16 = 16'h0; b16 = 16'h0;
        n_vec++;
        if ({alu_sel, alu_a, alu_b, alu_cin} !== {4'd0, 8'hF0, 8'h20, 1'b1}) begin
            n_err++; $display("FAIL step1_drive got sel=%0d a=%h b=%h cin=%b want sel=0 a=f0 b=20 cin=1", alu_sel, alu_a, alu_b, alu_cin);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL step1_busy got=%b want=1", busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({alu_sel, alu_a, alu_b, alu_cin} !== {4'd1, 8'h12, 8'h02, 1'b1}) begin
            n_err++; $display("FAIL step2_drive got sel=%0d a=%h b=%h cin=%b want sel=1 a=12 b=02 cin=1", alu_sel, alu_a, alu_b, alu_cin);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({busy, alu_sel, alu_a, alu_b, alu_cin} !== {1'b1, 21'h0}) begin
            n_err++; $display("FAIL finish_drive got busy=%b alu=%h want busy=1 alu=0", busy, {alu_sel, alu_a, alu_b, alu_cin});
        end
        @(posedge clk); #1;
        ref_apply(4'd0, 16'h12F0, 16'h0220, 1'b1);
        n_vec++;
        if ({done, busy, result16} !== {1'b1, 1'b0, exp_res}) begin
            n_err++; $display("FAIL drive_done got done=%b busy=%b res=%h want done=1 busy=0 res=%h", done, busy, result16, exp_res);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL done_pulse got=%b want=0", done);
        end
    endtask

`ifdef ALU16_SHIFT_EN
    task automatic test_shift;
        op = 4'd10; a16 = 16'h8001; b16 = 16'h0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if ({alu_sel, alu_a, alu_cin} !== {4'd10, 8'h80, 1'b1}) begin
            n_err++; $display("FAIL lsr_step1 got sel=%0d a=%h cin=%b want sel=10 a=80 cin=1", alu_sel, alu_a, alu_cin);
        end
        repeat (3) @(posedge clk);
        #1;
        ref_apply(4'd10, 16'h8001, 16'h0, 1'b1);
        n_vec++;
        if ({done, result16, c} !== {1'b1, 16'hC000, 1'b1}) begin
            n_err++; $display("FAIL lsr_8001 got done=%b res=%h c=%b want done=1 res=c000 c=1", done, result16, c);
        end
        check_op("asr_8002", 4'd13, 16'h8002, 16'h0000, 1'b1);
        check_op("rol_8000", 4'd11, 16'h8000, 16'h0000, 1'b0);
        check_op("ror_0001", 4'd12, 16'h0001, 16'h0000, 1'b0);
        check_op("lsl_c", 4'd9, 16'h4001, 16'h0000, 1'b1);
    endtask
`endif

    task automatic test_err_one(input logic [3:0] o);
        op = o; a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if ({err, done, busy} !== 3'b100) begin
            n_err++; $display("FAIL err_pulse op=%0d got err/done/busy=%b want=100", o, {err, done, busy});
        end
        n_vec++;
        if ({result16, c, z} !== {exp_res, exp_c, exp_z}) begin
            n_err++; $display("FAIL err_keep op=%0d got=%h %b%b want=%h %b%b", o, result16, c, z, exp_res, exp_c, exp_z);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({err, done, busy} !== 3'b000) begin
            n_err++; $display("FAIL err_after op=%0d got err/done/busy=%b want=000", o, {err, done, busy});
        end
    endtask

    task automatic test_err;
        test_err_one(4'd15);
`ifndef ALU16_SHIFT_EN
        test_err_one(4'd9);
        test_err_one(4'd13);
`endif
    endtask

    task automatic test_reset_mid;
        int seen;
        op = 4'd0; a16 = 16'h1111; b16 = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        exp_res = '0; exp_c = 1'b0; exp_z = 1'b0;
        n_vec++;
        if ({busy, done, result16, c, z} !== 20'h0) begin
            n_err++; $display("FAIL reset_mid got busy=%b done=%b res=%h c=%b z=%b want all 0", busy, done, result16, c, z);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_abort got %0d busy/done cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int seen;
        int lat1;
        int lat2;
        logic [15:0] a1;
        logic [15:0] b1;
        a1 = 16'($urandom); b1 = 16'($urandom);
        op = 4'd6; a16 = a1; b16 = b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ref_apply(4'd6, a1, b1, 1'b0);
        op = 4'd2; a16 = 16'h5555; b16 = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        if ({done, result16} !== {1'b1, exp_res}) begin
            n_err++; $display("FAIL busy_ignore got done=%b res=%h want done=1 res=%h", done, result16, exp_res);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL no_queue got %0d busy/done cycles want 0", seen);
        end
        do_op(4'd7, 16'hA5A5, 16'h0FF0, 1'b0, lat1);
        ref_apply(4'd7, 16'hA5A5, 16'h0FF0, 1'b0);
        do_op(4'd14, 16'h0000, 16'h7E81, 1'b0, lat2);
        ref_apply(4'd14, 16'h0000, 16'h7E81, 1'b0);
        n_vec++;
        if ({lat1, lat2} !== {32'd3, 32'd3}) begin
            n_err++; $display("FAIL b2b_latency got %0d,%0d want 3,3", lat1, lat2);
        end
        n_vec++;
        if ({result16, c, z} !== {exp_res, exp_c, exp_z}) begin
            n_err++; $display("FAIL b2b_result got=%h %b%b want=%h %b%b", result16, c, z, exp_res, exp_c, exp_z);
        end
    endtask

    task automatic test_random;
        logic [3:0] o;
        int idx;
        for (int n = 0; n < 40; n++) begin
`ifdef ALU16_SHIFT_EN
            o = 4'($urandom_range(0, 14));
`else
            idx = $urandom_range(0, 9);
            o = (idx == 9) ? 4'd14 : 4'(idx);
`endif
            idx = n;
            check_op("rand", o, 16'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_alu_drive();
`ifdef ALU16_SHIFT_EN
        test_shift();
`endif
        test_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        check_op("post_reset", 4'd1, 16'h7FFF, 16'h0000, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST_N  in  1  synchronous active-low reset.
REQ-004 START  in  1  request; sampled only in IDLE.
REQ-005 OP  in  4  8-bit ALU op code: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 EXOR, 8 TEST, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ASR, 14 MOV, 15 undefined.
REQ-006 A16, B16  in  16 each  operands; CIN  in  1  carry-in.
REQ-007 ALU_SEL  out  4, ALU_A  out  8, ALU_B  out  8, ALU_CIN  out  1  drive the combinational 8-bit ALU.
REQ-008 ALU_RESULT  in  8, ALU_C  in  1, ALU_Z  in  1  returned by the same ALU in the same cycle.
REQ-009 BUSY  out  1  high in STEP1, STEP2, FINISH.
REQ-010 DONE  out  1  one-cycle completion pulse; ERR  out  1  one-cycle pulse for rejected OP.
REQ-011 RESULT16  out  16, C  out  1, Z  out  1  registered 16-bit result and flags.

Function
REQ-012 FSM states: IDLE, STEP1, STEP2, FINISH; IDLE->STEP1 on START with supported OP; STEP1->STEP2->FINISH->IDLE unconditionally.
REQ-013 On accept, OP, A16, B16, CIN SHALL be latched; input changes afterwards have no effect.
REQ-014 START while BUSY SHALL be ignored (no queueing).
REQ-015 Latency: START sampled at edge N -> DONE high for exactly the cycle after edge N+3; next START accepted at edge N+4.
REQ-016 Left-type ops (0-9, 11, 14): STEP1 = low bytes, STEP2 = high bytes; right-type ops (10, 12, 13): STEP1 = high bytes, STEP2 = low bytes.
REQ-017 ADD/ADDC: STEP1 SEL 0/1 with ALU_CIN=CIN; STEP2 SEL 1 with ALU_CIN = STEP1 carry.
REQ-018 SUB/SUBC/CMP: STEP1 SEL 2/3/2 (CMP uses 2); STEP2 SEL 3 with ALU_CIN = STEP1 borrow.
REQ-019 AND/OR/EXOR/TEST/MOV: both steps same SEL as OP; C = STEP2 ALU_C.
REQ-020 LSL: SEL 9 both steps, STEP1 ALU_CIN=CIN, STEP2 ALU_CIN = STEP1 carry; ROL: same with STEP1 ALU_CIN = A16[15].
REQ-021 LSR: SEL 10 both steps, STEP1 ALU_CIN=CIN, STEP2 ALU_CIN = STEP1 carry; ROR: same with STEP1 ALU_CIN = A16[0]; ASR: STEP1 SEL 13, STEP2 SEL 10 with ALU_CIN = STEP1 carry.
REQ-022 ALU outputs SHALL be captured at the end of STEP1 and STEP2 into internal byte registers.
REQ-023 In FINISH: C = STEP2 ALU_C; Z = 1 iff both captured bytes are 0x00; RESULT16 = {hi,lo} except CMP/TEST, which update C/Z only and leave RESULT16 unchanged.
REQ-024 In IDLE and FINISH ALU_SEL, ALU_A, ALU_B, ALU_CIN SHALL be 0.
REQ-025 OP=15 with START in IDLE: ERR pulses next cycle, DONE stays 0, state stays IDLE, RESULT16/C/Z unchanged.

Reset
REQ-026 RST_N low at an edge SHALL force IDLE and RESULT16=0, C=0, Z=0, DONE=0, ERR=0, BUSY=0, ALU_* outputs 0, internal registers 0.
REQ-027 Reset mid-operation SHALL abort without DONE; a START in the same cycle as reset is dropped.

Configuration
REQ-028 Macro ALU16_SHIFT_EN defined: OPs 9-13 supported per REQ-020/021.
REQ-029 ALU16_SHIFT_EN undefined: OPs 9-13 treated as OP=15 (ERR, no state change) and shift sequencing logic is absent.

Verification
REQ-030 ADD A16=0x00FF B16=0x0001 CIN=0 -> DONE 3 cycles after accept, RESULT16=0x0100, C=0, Z=0.
REQ-031 SUB 0x0000-0x0001 -> RESULT16=0xFFFF, C=1, Z=0; then SUB 0x1000-0x0001 -> 0x0FFF, C=0.
REQ-032 RESULT16=0xABCD, then CMP 0x1234,0x1234 -> Z=1, C=0, RESULT16 stays 0xABCD.
REQ-033 (ALU16_SHIFT_EN) LSR 0x8001 CIN=1 -> 0xC000, C=1; ASR 0x8002 -> 0xC001, C=0; ROL 0x8000 -> 0x0001, C=1.
REQ-034 RST_N low during STEP2 -> next cycle BUSY=0, DONE never pulses, RESULT16=0; START during BUSY ignored.
REQ-035 OP=15 (and OP=9 without ALU16_SHIFT_EN) -> ERR one cycle, DONE=0, BUSY=0, outputs unchanged.
